jkff_monitor: RTL and testbench

//  Synthesizable response checker for a bank of JK flip-flops; the receiving end of jkff stimulus.

---
 rtl/jkff_monitor_if.sv | 42 ++++
 rtl/jkff_monitor.sv | 117 +++++++++++
 tb/tb_jkff_monitor.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jkff_monitor_if.sv
// jkff_monitor_if
//   Bundles the stimulus/response signals between a JK flop bank under test
//   (plus whatever drives it) and the jkff_monitor response checker.
//   master : side that drives en/j/k and the flop outputs q/qb
//   slave  : the monitor; samples en/j/k/q/qb, drives the status outputs
//   en             level, 1 = check lanes
//   j, k           J/K inputs seen by the flops (WIDTH)
//   q, qb          flop outputs and complemented outputs (WIDTH)
//   err            one-cycle pulse, previous compare failed
//   err_sticky     set on first error, cleared only by rst
//   err_mask       failing lanes of the previous compare (WIDTH)
//   first_err_mask err_mask captured at the first error (WIDTH)
//   err_cnt        saturating failing-compare count (CNT_W)
//   chk_cnt        saturating compare count (CNT_W)
//   state          00 IDLE, 01 CHECK, 10 FAIL
interface jkff_monitor_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             err;
  logic             err_sticky;
  logic [WIDTH-1:0] err_mask;
  logic [WIDTH-1:0] first_err_mask;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;
  logic [1:0]       state;

  modport master (
    output en, j, k, q, qb,
    input  err, err_sticky, err_mask, first_err_mask, err_cnt, chk_cnt, state
  );

  modport slave (
    input  en, j, k, q, qb,
    output err, err_sticky, err_mask, first_err_mask, err_cnt, chk_cnt, state
  );
endinterface

// File: rtl/jkff_monitor.sv
// jkff_monitor
//   Response checker for a bank of WIDTH JK flip-flops sharing clk/rst with
//   the monitor. Runs its own JK reference model on every edge and compares
//   the sampled q/qb against it while checking is enabled. Keeps saturating
//   error/compare counters and sticky first-error information.
//   clk  in  rising-edge clock shared with the monitored flops
//   rst  in  asynchronous active-high reset shared with the monitored flops
//   mon  jkff_monitor_if.slave : en/j/k/q/qb in, status/statistics out
//   Parameters: WIDTH lanes, CNT_W counter width, HALT_ON_ERR stop on first error.
module jkff_monitor #(
  parameter int WIDTH       = 1,
  parameter int CNT_W       = 8,
  parameter int HALT_ON_ERR = 0
) (
  input  logic          clk,
  input  logic          rst,
  jkff_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    FAIL  = 2'b10
  } state_t;

  state_t           st_q, st_d;
  logic [WIDTH-1:0] q_exp, q_exp_d;
  logic [WIDTH-1:0] fail_lanes;
  logic             any_fail;
  logic             do_cmp;

  logic             err_q;
  logic             sticky_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] first_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] chk_cnt_q;

  // Reference model: hold / reset / set / toggle per lane.
  always_comb begin
    q_exp_d = (mon.j & ~mon.k) | (~mon.j & ~mon.k & q_exp) | (mon.j & mon.k & ~q_exp);
  end

  // Sampled q/qb come from the same edge that produced q_exp.
  always_comb begin
    fail_lanes = (mon.q ^ q_exp) | (mon.qb ^ ~q_exp);
    any_fail   = |fail_lanes;
  end

  // A failing first compare straight out of IDLE also halts, so the FAIL
  // state always reflects the first error when halting is enabled.
  always_comb begin
    st_d   = st_q;
    do_cmp = 1'b0;
    case (st_q)
      IDLE: begin
        if (mon.en) begin
          do_cmp = 1'b1;
          st_d   = ((HALT_ON_ERR != 0) && any_fail) ? FAIL : CHECK;
        end
      end
      CHECK: begin
        if (!mon.en) begin
          st_d = IDLE;
        end else begin
          do_cmp = 1'b1;
          if ((HALT_ON_ERR != 0) && any_fail) st_d = FAIL;
        end
      end
      FAIL:    st_d = FAIL;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      q_exp <= '0;
    end else begin
      st_q  <= st_d;
      q_exp <= q_exp_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      mask_q    <= '0;
      sticky_q  <= 1'b0;
      first_q   <= '0;
      err_cnt_q <= '0;
      chk_cnt_q <= '0;
    end else begin
      err_q  <= do_cmp & any_fail;
      mask_q <= do_cmp ? fail_lanes : '0;
      if (do_cmp) begin
        if (chk_cnt_q != '1) chk_cnt_q <= chk_cnt_q + 1'b1;
        if (any_fail) begin
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
          if (!sticky_q) begin
            sticky_q <= 1'b1;
            first_q  <= fail_lanes;
          end
        end
      end
    end
  end

  assign mon.err            = err_q;
  assign mon.err_sticky     = sticky_q;
  assign mon.err_mask       = mask_q;
  assign mon.first_err_mask = first_q;
  assign mon.err_cnt        = err_cnt_q;
  assign mon.chk_cnt        = chk_cnt_q;
  assign mon.state          = st_q;

endmodule

// File: tb/tb_jkff_monitor.sv
// tb_jkff_monitor
//   Drives three monitor instances (HALT_ON_ERR=0 / HALT_ON_ERR=1 / CNT_W=3)
//   with a shared 4-lane JK flop bank whose outputs can be corrupted, and
//   compares every instance against a behavioural model of the monitor.
module tb_jkff_monitor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [W-1:0] j   = '0;
  logic [W-1:0] k   = '0;
  logic [W-1:0] q   = '0;
  logic [W-1:0] qb  = '1;

  // fault controls applied to the flop bank outputs
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] flipm  = '0;
  logic         qb_tied = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jkff_monitor_if #(.WIDTH(W), .CNT_W(8)) if0 ();
  jkff_monitor_if #(.WIDTH(W), .CNT_W(8)) if1 ();
  jkff_monitor_if #(.WIDTH(W), .CNT_W(3)) if2 ();

  assign if0.en = en; assign if0.j = j; assign if0.k = k; assign if0.q = q; assign if0.qb = qb;
  assign if1.en = en; assign if1.j = j; assign if1.k = k; assign if1.q = q; assign if1.qb = qb;
  assign if2.en = en; assign if2.j = j; assign if2.k = k; assign if2.q = q; assign if2.qb = qb;

  jkff_monitor #(.WIDTH(W), .CNT_W(8), .HALT_ON_ERR(0)) dut0 (.clk(clk), .rst(rst), .mon(if0.slave));
  jkff_monitor #(.WIDTH(W), .CNT_W(8), .HALT_ON_ERR(1)) dut1 (.clk(clk), .rst(rst), .mon(if1.slave));
  jkff_monitor #(.WIDTH(W), .CNT_W(3), .HALT_ON_ERR(0)) dut2 (.clk(clk), .rst(rst), .mon(if2.slave));

  // packed observation: err, sticky, mask, first, err_cnt, chk_cnt, state
  logic [27:0] obs [3];
  assign obs[0] = {if0.err, if0.err_sticky, if0.err_mask, if0.first_err_mask, if0.err_cnt, if0.chk_cnt, if0.state};
  assign obs[1] = {if1.err, if1.err_sticky, if1.err_mask, if1.first_err_mask, if1.err_cnt, if1.chk_cnt, if1.state};
  assign obs[2] = {if2.err, if2.err_sticky, if2.err_mask, if2.first_err_mask, 5'd0, if2.err_cnt, 5'd0, if2.chk_cnt, if2.state};

  // behavioural model of the flop bank (mq) and of each monitor instance
  logic [W-1:0] mq;
  int           m_chk    [3];
  int           m_errc   [3];
  logic         m_err    [3];
  logic [W-1:0] m_mask   [3];
  logic         m_sticky [3];
  logic [W-1:0] m_first  [3];
  logic         m_failed [3];
  logic [1:0]   m_state  [3];

  function automatic int cmax(input int c);
    return (c == 2) ? 7 : 255;
  endfunction

  function automatic logic [27:0] exp_vec(input int c);
    return {m_err[c], m_sticky[c], m_mask[c], m_first[c], 8'(m_errc[c]), 8'(m_chk[c]), m_state[c]};
  endfunction

  task automatic model_clear();
    mq = '0;
    for (int c = 0; c < 3; c++) begin
      m_chk[c] = 0; m_errc[c] = 0; m_err[c] = 1'b0; m_mask[c] = '0;
      m_sticky[c] = 1'b0; m_first[c] = '0; m_failed[c] = 1'b0; m_state[c] = 2'd0;
    end
  endtask

  // One clock edge of the model, using the values the DUTs sampled.
  task automatic model_edge();
    logic [W-1:0] fl;
    fl = (q ^ mq) | (qb ^ ~mq);
    for (int c = 0; c < 3; c++) begin
      m_err[c]  = 1'b0;
      m_mask[c] = '0;
      if (en && !m_failed[c]) begin
        if (m_chk[c] < cmax(c)) m_chk[c]++;
        if (fl != '0) begin
          m_err[c]  = 1'b1;
          m_mask[c] = fl;
          if (m_errc[c] < cmax(c)) m_errc[c]++;
          if (!m_sticky[c]) begin
            m_sticky[c] = 1'b1;
            m_first[c]  = fl;
          end
          if (c == 1) m_failed[c] = 1'b1;
        end
      end
      m_state[c] = m_failed[c] ? 2'd2 : (en ? 2'd1 : 2'd0);
    end
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b00: mq[i] = mq[i];
        2'b01: mq[i] = 1'b0;
        2'b10: mq[i] = 1'b1;
        default: mq[i] = ~mq[i];
      endcase
    end
  endtask

  task automatic drive_flops();
    q  = (mq & ~stuck0) ^ flipm;
    qb = qb_tied ? q : ~mq;
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit later.
  task automatic cycle(input logic e, input logic [W-1:0] jj, input logic [W-1:0] kk);
    en = e; j = jj; k = kk;
    drive_flops();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0; stuck0 = '0; flipm = '0; qb_tied = 1'b0;
    model_clear();
    drive_flops();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs[c] !== 28'd0) begin
        failures++;
        $display("FAIL reset dut%0d: got %h expected %h", c, obs[c], 28'd0);
      end
    end
  endtask

  task automatic test_clean_sequence();
    logic [1:0] seq [7];
    seq = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01, 2'b10};
    do_reset();
    for (int n = 0; n < 7; n++) begin
      cycle(1'b1, {W{seq[n][1]}}, {W{seq[n][0]}});
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs[c] !== exp_vec(c)) begin
          failures++;
          $display("FAIL clean_seq dut%0d step%0d: got %h expected %h", c, n, obs[c], exp_vec(c));
        end
      end
      checks++;
      if (if0.err !== 1'b0) begin
        failures++;
        $display("FAIL clean_seq_err step%0d: got %b expected 0", n, if0.err);
      end
    end
    checks++;
    if (if0.chk_cnt !== 8'd7 || if0.err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL clean_seq_final: chk_cnt=%0d sticky=%b expected 7 0", if0.chk_cnt, if0.err_sticky);
    end
  endtask

  task automatic test_stuck_q();
    do_reset();
    stuck0 = 4'b0001;
    cycle(1'b1, 4'b1111, 4'b0000);
    checks++;
    if (if0.err !== 1'b0) begin
      failures++;
      $display("FAIL stuck_q_first: err got %b expected 0", if0.err);
    end
    cycle(1'b1, 4'b1111, 4'b0000);
    checks++;
    if (if0.err !== 1'b1 || if0.err_cnt !== 8'd1 || if0.err_mask !== 4'b0001 || if0.first_err_mask !== 4'b0001) begin
      failures++;
      $display("FAIL stuck_q_err: err=%b cnt=%0d mask=%b first=%b expected 1 1 0001 0001",
               if0.err, if0.err_cnt, if0.err_mask, if0.first_err_mask);
    end
    cycle(1'b0, 4'b0000, 4'b0000);
    checks++;
    if (if0.err !== 1'b0 || if0.err_mask !== 4'b0000 || if0.first_err_mask !== 4'b0001) begin
      failures++;
      $display("FAIL stuck_q_pulse: err=%b mask=%b first=%b expected 0 0000 0001",
               if0.err, if0.err_mask, if0.first_err_mask);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs[c] !== exp_vec(c)) begin
        failures++;
        $display("FAIL stuck_q_model dut%0d: got %h expected %h", c, obs[c], exp_vec(c));
      end
    end
    stuck0 = '0;
  endtask

  task automatic test_qb_tied();
    do_reset();
    qb_tied = 1'b1;
    cycle(1'b1, 4'b0000, 4'b0000);
    checks++;
    if (if0.err !== 1'b1 || if0.err_sticky !== 1'b1 || if0.state !== 2'b01 || if0.err_mask !== 4'b1111) begin
      failures++;
      $display("FAIL qb_tied: err=%b sticky=%b state=%b mask=%b expected 1 1 01 1111",
               if0.err, if0.err_sticky, if0.state, if0.err_mask);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs[c] !== exp_vec(c)) begin
        failures++;
        $display("FAIL qb_tied_model dut%0d: got %h expected %h", c, obs[c], exp_vec(c));
      end
    end
    qb_tied = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    cycle(1'b1, 4'b0000, 4'b0000);
    flipm = 4'b0100;
    cycle(1'b1, W'($urandom), W'($urandom));
    flipm = '0;
    for (int n = 0; n < 5; n++) begin
      cycle(1'b1, W'($urandom), W'($urandom));
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs[c] !== exp_vec(c)) begin
          failures++;
          $display("FAIL halt_model dut%0d step%0d: got %h expected %h", c, n, obs[c], exp_vec(c));
        end
      end
    end
    checks++;
    if (if1.state !== 2'b10 || if1.err_cnt !== 8'd1 || if1.chk_cnt !== 8'd2 || if1.first_err_mask !== 4'b0100) begin
      failures++;
      $display("FAIL halt_final: state=%b err_cnt=%0d chk_cnt=%0d first=%b expected 10 1 2 0100",
               if1.state, if1.err_cnt, if1.chk_cnt, if1.first_err_mask);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 10; n++) begin
      flipm = W'($urandom_range(1, 15));
      cycle(1'b1, W'($urandom), W'($urandom));
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs[c] !== exp_vec(c)) begin
          failures++;
          $display("FAIL sat_model dut%0d step%0d: got %h expected %h", c, n, obs[c], exp_vec(c));
        end
      end
    end
    flipm = '0;
    checks++;
    if (if2.err_cnt !== 3'd7 || if2.chk_cnt !== 3'd7 || if2.err !== 1'b1 || if2.err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL sat_final: err_cnt=%0d chk_cnt=%0d err=%b sticky=%b expected 7 7 1 1",
               if2.err_cnt, if2.chk_cnt, if2.err, if2.err_sticky);
    end
    checks++;
    if (if0.err_cnt !== 8'd10) begin
      failures++;
      $display("FAIL sat_wide_cnt: got %0d expected 10", if0.err_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    flipm = 4'b0010;
    cycle(1'b1, 4'b1010, 4'b0110);
    flipm = '0;
    cycle(1'b1, 4'b1111, 4'b0000);
    #2;
    rst = 1'b1;
    en = 1'b0;
    model_clear();
    drive_flops();
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (obs[c] !== 28'd0) begin
        failures++;
        $display("FAIL async_reset dut%0d: got %h expected %h", c, obs[c], 28'd0);
      end
    end
    rst = 1'b0;
    cycle(1'b1, 4'b1111, 4'b1111);
    cycle(1'b1, 4'b1111, 4'b1111);
    checks++;
    if (mq !== 4'b0000 || if0.err !== 1'b0 || if0.err_sticky !== 1'b0 || if0.chk_cnt !== 8'd2) begin
      failures++;
      $display("FAIL async_reset_resume: err=%b sticky=%b chk_cnt=%0d expected 0 0 2",
               if0.err, if0.err_sticky, if0.chk_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      flipm   = ($urandom_range(0, 7) == 0) ? W'($urandom_range(1, 15)) : '0;
      qb_tied = ($urandom_range(0, 31) == 0);
      cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom));
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs[c] !== exp_vec(c)) begin
          failures++;
          $display("FAIL random dut%0d step%0d: got %h expected %h", c, n, obs[c], exp_vec(c));
        end
      end
    end
    flipm = '0;
    qb_tied = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_sequence();
    test_stuck_q();
    test_qb_tied();
    test_halt();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
